imem_loadable: RTL and testbench

//  Byte-addressed instruction memory with a synchronous, registered fetch port and a

---
 rtl/imem_loadable.sv | 125 ++++++++++++
 tb/tb_imem_loadable.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// imem_loadable: byte-addressed instruction memory with a byte-serial program
// loader and a one-cycle registered 32-bit fetch port. Fetches are served only
// in RUN; misaligned or out-of-range fetches return NOP_INST with a fault flag.
module imem_loadable #(
  parameter int          MEM_NBYTE = 4096,
  parameter int          LOAD_BASE = 0,
  parameter logic [31:0] NOP_INST  = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_end,
  output logic        ld_ready,
  output logic        ld_overflow,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        fetch_fault,
  output logic        running
);

  localparam int AW        = $clog2(MEM_NBYTE);
  localparam int PW        = AW + 1;   // one extra bit so the pointer can sit at MEM_NBYTE
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                          state;
  logic [PW-1:0]                   ld_ptr;
  logic [7:0]                      mem [MEM_NBYTE];
  logic [NUM_LANES-1:0][7:0]       rd_lane;
  logic [AW-1:0]                   rd_idx;
  logic                            wr_en;
  logic                            fetch_acc;
  logic                            fetch_bad;

  assign ld_ready = (state == LOAD) && (ld_ptr < PW'(MEM_NBYTE));
  assign running  = (state == RUN);

  // ld_start owns the cycle: a byte offered alongside it is dropped
  assign wr_en = !rst && (state == LOAD) && !ld_start && ld_valid && ld_ready;

  // A request in the same cycle as RUN->LOAD is not served
  assign fetch_acc = (state == RUN) && fetch_req && !ld_start;
  assign fetch_bad = (|fetch_addr[1:0]) || (fetch_addr > 32'(MEM_NBYTE - 4));

  // Index is truncated to AW bits, so even a faulting address stays inside
  // the array; the lane data is simply discarded in that case.
  assign rd_idx = fetch_addr[AW-1:0];

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      assign rd_lane[g] = mem[rd_idx + AW'(g)];
    end
  endgenerate

  // Program store: written only by the loader, never cleared by reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[ld_ptr[AW-1:0]] <= ld_byte;
  end

  // Session FSM: IDLE -> LOAD -> RUN -> LOAD ..., ld_start beats ld_end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ld_ptr      <= PW'(LOAD_BASE);
      ld_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_start) begin
            state       <= LOAD;
            ld_ptr      <= PW'(LOAD_BASE);
            ld_overflow <= 1'b0;
          end
        end
        LOAD: begin
          if (ld_start) begin
            ld_ptr      <= PW'(LOAD_BASE);
            ld_overflow <= 1'b0;
          end else begin
            if (ld_valid) begin
              if (ld_ready) ld_ptr      <= ld_ptr + PW'(1);
              else          ld_overflow <= 1'b1;
            end
            if (ld_end) state <= RUN;
          end
        end
        RUN: begin
          if (ld_start) begin
            state       <= LOAD;
            ld_ptr      <= PW'(LOAD_BASE);
            ld_overflow <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Fetch pipeline: one stage; inst/fetch_fault hold when nothing is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      inst        <= '0;
      inst_valid  <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      inst_valid <= fetch_acc;
      if (fetch_acc) begin
        if (fetch_bad) begin
          inst        <= NOP_INST;
          fetch_fault <= 1'b1;
        end else begin
          inst        <= rd_lane;
          fetch_fault <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: drives a 4096-byte and an 8-byte instance with the same
// stimulus and compares both against a per-size behavioural memory model.
module tb_imem_loadable;

  logic        clk;
  logic        rst;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_end;
  logic        fetch_req;
  logic [31:0] fetch_addr;

  logic        rdy  [2];
  logic        ovf  [2];
  logic [31:0] inst [2];
  logic        vld  [2];
  logic        flt  [2];
  logic        run  [2];

  int n_chk = 0;
  int n_err = 0;

  // model state, index 0 = 4096-byte instance, 1 = 8-byte instance
  int          sz    [2] = '{4096, 8};
  logic [7:0]  m_mem [2][4096];
  int          m_st  [2];   // 0 idle, 1 load, 2 run
  int          m_ptr [2];
  bit          m_ovf [2];
  bit          m_vld [2];
  bit          m_flt [2];
  logic [31:0] m_inst[2];

  imem_loadable #(.MEM_NBYTE(4096)) u_big (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_end(ld_end), .ld_ready(rdy[0]),
    .ld_overflow(ovf[0]), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .inst(inst[0]), .inst_valid(vld[0]), .fetch_fault(flt[0]), .running(run[0])
  );

  imem_loadable #(.MEM_NBYTE(8)) u_small (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_end(ld_end), .ld_ready(rdy[1]),
    .ld_overflow(ovf[1]), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .inst(inst[1]), .inst_valid(vld[1]), .fetch_fault(flt[1]), .running(run[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model of one clock edge, from the documented session/fetch rules
  task automatic model_step(input int i);
    longint a;
    if (rst) begin
      m_st[i] = 0; m_ptr[i] = 0; m_ovf[i] = 0;
      m_vld[i] = 0; m_flt[i] = 0; m_inst[i] = 32'h0;
      return;
    end
    a = longint'(fetch_addr);
    m_vld[i] = (m_st[i] == 2) && fetch_req && !ld_start;
    if (m_vld[i]) begin
      if ((a % 4) != 0 || a > longint'(sz[i] - 4)) begin
        m_flt[i]  = 1;
        m_inst[i] = 32'h00000013;
      end else begin
        m_flt[i]  = 0;
        m_inst[i] = {m_mem[i][int'(a)+3], m_mem[i][int'(a)+2],
                     m_mem[i][int'(a)+1], m_mem[i][int'(a)]};
      end
    end
    case (m_st[i])
      0: if (ld_start) begin m_st[i] = 1; m_ptr[i] = 0; m_ovf[i] = 0; end
      1: begin
        if (ld_start) begin
          m_ptr[i] = 0; m_ovf[i] = 0;
        end else begin
          if (ld_valid) begin
            if (m_ptr[i] < sz[i]) begin
              m_mem[i][m_ptr[i]] = ld_byte;
              m_ptr[i]++;
            end else m_ovf[i] = 1;
          end
          if (ld_end) m_st[i] = 2;
        end
      end
      default: if (ld_start) begin m_st[i] = 1; m_ptr[i] = 0; m_ovf[i] = 0; end
    endcase
  endtask

  task automatic check_dut(input int i);
    chk($sformatf("ld_ready[%0d]", i), 32'(rdy[i]), 32'((m_st[i] == 1) && (m_ptr[i] < sz[i])));
    chk($sformatf("ld_overflow[%0d]", i), 32'(ovf[i]), 32'(m_ovf[i]));
    chk($sformatf("running[%0d]", i), 32'(run[i]), 32'(m_st[i] == 2));
    chk($sformatf("inst_valid[%0d]", i), 32'(vld[i]), 32'(m_vld[i]));
    chk($sformatf("inst[%0d]", i), inst[i], m_inst[i]);
    chk($sformatf("fetch_fault[%0d]", i), 32'(flt[i]), 32'(m_flt[i]));
  endtask

  // One clock: inputs already set, advance model, sample after the edge
  task automatic cyc();
    for (int i = 0; i < 2; i++) model_step(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_dut(i);
  endtask

  task automatic quiet();
    rst = 0; ld_start = 0; ld_valid = 0; ld_end = 0; ld_byte = 8'h00;
    fetch_req = 0; fetch_addr = 32'h0;
  endtask

  task automatic do_start();
    quiet(); ld_start = 1; cyc(); quiet();
  endtask

  task automatic put_byte(input logic [7:0] b, input logic last);
    quiet(); ld_valid = 1; ld_byte = b; ld_end = last; cyc(); quiet();
  endtask

  task automatic do_end();
    quiet(); ld_end = 1; cyc(); quiet();
  endtask

  task automatic fetch(input logic [31:0] a);
    quiet(); fetch_req = 1; fetch_addr = a; cyc(); quiet();
  endtask

  logic [7:0] prog [8] = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
  logic [31:0] bnd [7] = '{32'd4, 32'd8, 32'd12, 32'd4092, 32'd4093, 32'd4096, 32'hFFFFFFFC};

  initial begin
    quiet();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_ptr[i] = 0; m_ovf[i] = 0; m_vld[i] = 0; m_flt[i] = 0; m_inst[i] = 0;
    end
    #2;
    // reset state
    rst = 1; cyc(); rst = 0;

    // fill the whole big array so every later fetch has a known value;
    // the small instance overflows after its 8th byte
    do_start();
    for (int k = 0; k < 4097; k++) put_byte(8'($urandom), 1'b0);
    chk("big_overflow_after_fill", 32'(ovf[0]), 32'd1);
    do_end();

    // documented program load and fetches
    rst = 1; cyc(); rst = 0;
    fetch(32'h0);                              // ignored in IDLE
    do_start();
    fetch(32'h0);                              // ignored in LOAD
    for (int k = 0; k < 8; k++) put_byte(prog[k], 1'b0);
    do_end();
    chk("running_after_end", 32'(run[0]), 32'd1);
    fetch(32'h0);
    chk("word0", inst[0], 32'h00100013);
    chk("word0_valid", 32'(vld[0]), 32'd1);
    fetch(32'h4);
    chk("word4", inst[0], 32'h00500093);
    // back-to-back 0,4,0
    quiet(); fetch_req = 1; fetch_addr = 32'h0; cyc();
    fetch_addr = 32'h4; cyc();
    fetch_addr = 32'h0; cyc();
    quiet(); cyc();
    fetch(32'h2);
    chk("misalign_fault", 32'(flt[0]), 32'd1);
    chk("misalign_nop", inst[0], 32'h00000013);
    for (int k = 0; k < 7; k++) fetch(bnd[k]);

    // RUN->LOAD with a fetch request on the same edge
    quiet(); ld_start = 1; fetch_req = 1; fetch_addr = 32'h0; cyc(); quiet();

    // 9 bytes into the 8-byte instance, then clear via ld_start
    for (int k = 0; k < 9; k++) put_byte(8'($urandom), 1'b0);
    chk("small_overflow", 32'(ovf[1]), 32'd1);
    chk("small_not_ready", 32'(rdy[1]), 32'd0);
    do_start();
    chk("small_overflow_clr", 32'(ovf[1]), 32'd0);

    // last byte arriving with ld_end
    for (int k = 0; k < 3; k++) put_byte(8'(k + 1), 1'b0);
    put_byte(8'hA5, 1'b1);
    fetch(32'h0);
    chk("byte_with_end", inst[0], 32'hA5030201);

    // reset mid-load, fetches ignored, then reload
    do_start();
    put_byte(8'h11, 1'b0);
    put_byte(8'h22, 1'b0);
    rst = 1; fetch_req = 1; cyc(); quiet();
    fetch(32'h0);
    chk("no_fetch_after_rst", 32'(vld[0]), 32'd0);
    do_start();
    put_byte(8'hEF, 1'b0); put_byte(8'hBE, 1'b0); put_byte(8'hAD, 1'b0); put_byte(8'hDE, 1'b0);
    do_end();
    fetch(32'h0);
    chk("reload_word", inst[0], 32'hDEADBEEF);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int mode;
      quiet();
      rst       = ($urandom_range(0, 499) == 0);
      ld_start  = ($urandom_range(0, 39) == 0);
      ld_end    = ($urandom_range(0, 29) == 0);
      ld_valid  = $urandom_range(0, 1) == 1;
      ld_byte   = 8'($urandom);
      fetch_req = $urandom_range(0, 1) == 1;
      mode = $urandom_range(0, 3);
      case (mode)
        0:       fetch_addr = 32'($urandom_range(0, 15) * 4);
        1:       fetch_addr = $urandom;
        2:       fetch_addr = bnd[$urandom_range(0, 6)];
        default: fetch_addr = 32'($urandom_range(0, 4095));
      endcase
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
